seg_reverse_pipe: RTL and testbench
===================================

Name: seg_reverse_pipe

Overview:
- Pipelined, handshaked successor of the combinational segment-reverse used in SAUS input selection.
- Reverses each aligned segment of a LANES-wide coefficient vector.
- Segment size is selected per transaction at run time, not fixed by a parameter.
- Optional odd-lane negation produces DCT-VIII inputs from the DST-VII datapath.
- Sits between input selection and the butterfly core; valid/ready on both sides, full throughput.

Parameters:
- WIDTH, 16, signed sample width in bits.
- LANES, 32, vector lanes; power of two, 4..64.
- SEGW, $clog2($clog2(LANES))+1, width of the segment-size select field (derived; do not override).
- TAGW, 8, width of the sideband tag carried alongside data.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts input this cycle.
- in_vector  in  signed [WIDTH-1:0] x LANES  input samples, lane 0 first.
- in_seg_log2  in  SEGW  log2 of segment size S; legal range 2..log2(LANES).
- in_mode  in  2  00 pass, 01 reverse, 10 reverse+negate odd lanes, 11 reserved (treated as 00).
- in_tag  in  TAGW  sideband, returned unchanged.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- out_vector  out  signed [WIDTH-1:0] x LANES  result samples.
- out_tag  out  TAGW  tag of the transaction in out_vector.
- err_seg  out  1  sticky flag: an illegal in_seg_log2 or in_mode=11 was accepted.

Behaviour:
- Transfer occurs on a cycle where valid && ready, at either port.
- Two register stages, S1 then S2.
  - Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput: 1 vector per cycle.
- Stage advance rule: stage k loads when it is empty or its content leaves this cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - in_ready is combinational from out_ready; no skid buffer.
- S1 (permute), S = 2^in_seg_log2:
  - Reverse modes: s1[i] = in_vector[i XOR (S-1)] for every lane i.
  - Equivalent to new_pos = base + (S-1 - pos mod S), segments aligned to multiples of S.
  - Mode 00: s1[i] = in_vector[i].
- S1 captures the following alongside data: mode, tag, and a legality bit.
  - Illegal means in_seg_log2 < 2, in_seg_log2 > log2(LANES), or mode=11.
  - An illegal transaction is forced to pass mode.
- S2 (sign): in mode 10, lanes with (i mod S) odd are negated.
  - Negation saturates: -(-2^(WIDTH-1)) = 2^(WIDTH-1)-1.
  - All other values are negated exactly.
  - All other lanes and modes are copied unchanged.
- err_seg sets in the cycle after an illegal transaction transfers into S1.
  - It stays set until rst; it does not stall or drop the transaction.
- Backpressure: while out_valid && !out_ready, out_vector and out_tag hold stable.
  - Upstream may fill S1, then in_ready drops.
  - No data loss or duplication.
- Simultaneous input transfer and output transfer with both stages full: all stages shift in the same cycle.
- Reset values:
  - s1_valid=0, s2_valid=0, out_valid=0, err_seg=0.
  - out_vector=0, out_tag=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight vectors are discarded and no output transfers after rst is sampled high.
- Data registers update only when the stage loads; no free-running capture.

Test Plan:
- Pipeline latency: LANES=32, in_vector[i]=i, seg_log2=2, mode 01, tag=0x5A, out_ready=1.
  - out_vector = 3,2,1,0,7,6,5,4,...,31,30,29,28.
  - out_tag=0x5A; out_valid exactly 2 cycles after transfer.
- Full reverse with negation: seg_log2=5, mode 10, in_vector[i]=i+1.
  - out[0]=32, out[1]=-31, out[2]=30, ..., out[31]=-1.
- Saturation: WIDTH=16, seg_log2=2, mode 10, lane 2 = -32768, others 0.
  - out[1]=32767; all other lanes 0.
- Backpressure: stream 6 vectors with tags 1..6, out_ready low for cycles 3..7.
  - Outputs arrive in order 1..6, none lost or duplicated.
  - in_ready low while both stages are full; out_vector stable while stalled.
- Illegal select: seg_log2=1, mode 01, in_vector[i]=i.
  - out_vector = in_vector unchanged; err_seg=1 from the next cycle and held.
  - Subsequent legal transactions process normally.
- Reset mid-stream: assert rst with both stages full.
  - Next cycle: out_valid=0, err_seg=0, in_ready=1.
  - The first post-reset vector emerges after 2 cycles.

Source files
------------

// File: rtl/seg_reverse_pipe.sv
// rtl/seg_reverse_pipe.sv - two-stage handshaked segment reverse with optional odd-lane saturating negation
// Vectors are packed lane 0 at the least significant WIDTH bits; samples are two's complement.
module seg_reverse_pipe #(
   parameter int WIDTH = 16,
   parameter int LANES = 32,
   parameter int SEGW  = $clog2($clog2(LANES)) + 1,
   parameter int TAGW  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES-1:0][WIDTH-1:0]   in_vector,
   input  logic [SEGW-1:0]               in_seg_log2,
   input  logic [1:0]                    in_mode,
   input  logic [TAGW-1:0]               in_tag,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0][WIDTH-1:0]   out_vector,
   output logic [TAGW-1:0]               out_tag,
   output logic                          err_seg
);

   localparam int LOG2L = $clog2(LANES);
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

   logic                        s1_valid;
   logic [LANES-1:0][WIDTH-1:0] s1_data;
   logic [TAGW-1:0]             s1_tag;
   logic [1:0]                  s1_mode;
   logic                        s1_illegal;

   logic                        s2_valid;
   logic [LANES-1:0][WIDTH-1:0] s2_data;
   logic [TAGW-1:0]             s2_tag;

   logic                        s1_load;
   logic                        s2_load;
   logic                        in_fire;
   logic                        seg_ok;
   logic                        in_illegal;
   logic [1:0]                  eff_mode;
   logic [LOG2L-1:0]            mask;
   logic [LANES-1:0][WIDTH-1:0] perm;
   logic                        neg;
   logic [LANES-1:0][WIDTH-1:0] signed_data;

   // A stage may load when empty or when its occupant leaves this same cycle.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;
   assign in_fire  = in_valid && s1_load;

   assign out_valid  = s2_valid;
   assign out_vector = s2_data;
   assign out_tag    = s2_tag;

   always_comb begin
      seg_ok     = (in_seg_log2 >= SEGW'(2)) && (in_seg_log2 <= SEGW'(LOG2L));
      in_illegal = !seg_ok || (in_mode == 2'b11);
      eff_mode   = in_illegal ? 2'b00 : in_mode;
      mask       = '0;
      // XOR with S-1 mirrors each lane inside its aligned segment.
      if (eff_mode != 2'b00) begin
         mask = LOG2L'((32'd1 << in_seg_log2) - 32'd1);
      end
      for (int i = 0; i < LANES; i++) begin
         perm[i] = in_vector[LOG2L'(i) ^ mask];
      end
   end

   // Segments are at least 4 lanes, so odd position within a segment is odd lane index.
   always_comb begin
      neg = (s1_mode == 2'b10) && !s1_illegal;
      for (int i = 0; i < LANES; i++) begin
         if (neg && ((i % 2) != 0)) begin
            signed_data[i] = (s1_data[i] == SMIN) ? SMAX : -s1_data[i];
         end else begin
            signed_data[i] = s1_data[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_data    <= '0;
         s1_tag     <= '0;
         s1_mode    <= 2'b00;
         s1_illegal <= 1'b0;
         s2_valid   <= 1'b0;
         s2_data    <= '0;
         s2_tag     <= '0;
         err_seg    <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
         end
         if (in_fire) begin
            s1_data    <= perm;
            s1_tag     <= in_tag;
            s1_mode    <= eff_mode;
            s1_illegal <= in_illegal;
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
         end
         if (s2_load && s1_valid) begin
            s2_data <= signed_data;
            s2_tag  <= s1_tag;
         end
         if (in_fire && in_illegal) begin
            err_seg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_reverse_pipe.sv
// tb/tb_seg_reverse_pipe.sv - scoreboard bench for seg_reverse_pipe against a segment-level reference model
module tb_seg_reverse_pipe;

   localparam int WIDTH = 16;
   localparam int LANES = 32;
   localparam int TAGW  = 8;
   localparam int SEGW  = 4;
   localparam int LOG2L = 5;

   typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
   typedef struct {
      vec_t            v;
      logic [TAGW-1:0] tag;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   vec_t            in_vector;
   logic [SEGW-1:0] in_seg_log2;
   logic [1:0]      in_mode;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   vec_t            out_vector;
   logic [TAGW-1:0] out_tag;
   logic            err_seg;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pushes = 0;
   int   pops   = 0;
   vec_t last_v = '0;
   logic [TAGW-1:0] last_tag = '0;
   logic stalled = 1'b0;
   vec_t hold_v;
   logic [TAGW-1:0] hold_tag;
   logic rand_done;

   always #5 clk = ~clk;

   seg_reverse_pipe #(.WIDTH(WIDTH), .LANES(LANES), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
      .in_seg_log2(in_seg_log2), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
      .out_tag(out_tag), .err_seg(err_seg)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: mirror each aligned segment of size S, then negate odd in-segment positions.
   function automatic vec_t model(input vec_t v, input int seg, input int mode);
      vec_t r;
      int   s;
      int   n;
      logic signed [WIDTH-1:0] x;
      if (seg < 2 || seg > LOG2L || mode == 3 || mode == 0) return v;
      s = 1 << seg;
      for (int base = 0; base < LANES; base += s)
         for (int k = 0; k < s; k++)
            r[base + s - 1 - k] = v[base + k];
      if (mode == 2) begin
         for (int i = 0; i < LANES; i++) begin
            if (((i % s) % 2) == 1) begin
               x = r[i];
               n = -int'(x);
               if (n > 32767) n = 32767;
               r[i] = WIDTH'(n);
            end
         end
      end
      return r;
   endfunction

   task automatic send(input vec_t v, input int seg, input int mode, input logic [TAGW-1:0] tag);
      exp_t e;
      int   n;
      in_vector   = v;
      in_seg_log2 = SEGW'(seg);
      in_mode     = 2'(mode);
      in_tag      = tag;
      in_valid    = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tag %0h never accepted", tag);
      end else begin
         e.v   = model(v, seg, mode);
         e.tag = tag;
         sb.push_back(e);
         pushes++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < LANES; i++) v[i] = WIDTH'($urandom);
      return v;
   endfunction

   // Monitor: pops the scoreboard on every output transfer, checks hold while stalled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) begin
               chkv("hold_vector", out_vector, hold_v);
               chk("hold_tag", out_tag, hold_tag);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: tag %0h with empty scoreboard", out_tag);
               end else begin
                  e = sb.pop_front();
                  pops++;
                  chkv("out_vector", out_vector, e.v);
                  chk("out_tag", out_tag, e.tag);
                  last_v   = out_vector;
                  last_tag = out_tag;
               end
            end
            stalled  = out_valid && !out_ready;
            hold_v   = out_vector;
            hold_tag = out_tag;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vec_t t;
      int   n;
      rst = 1'b1;
      in_valid = 1'b0;
      in_vector = '0;
      in_seg_log2 = '0;
      in_mode = 2'b00;
      in_tag = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err_seg", err_seg, 0);
      chk("rst_in_ready", in_ready, 1);
      chkv("rst_out_vector", out_vector, '0);
      chk("rst_out_tag", out_tag, 0);
      @(posedge clk);
      #1;

      // Latency and 4-lane reverse
      for (int i = 0; i < LANES; i++) v[i] = WIDTH'(i);
      send(v, 2, 1, 8'h5a);
      @(negedge clk);
      chk("lat_cycle1_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      chk("lat_lane0", last_v[0], 3);
      chk("lat_lane4", last_v[4], 7);
      chk("lat_lane31", last_v[31], 28);
      chk("lat_tag", last_tag, 8'h5a);

      // Full reverse with negation
      for (int i = 0; i < LANES; i++) v[i] = WIDTH'(i + 1);
      send(v, 5, 2, 8'h22);
      repeat (3) @(posedge clk);
      #1;
      chk("neg_lane0", last_v[0], 32);
      chk("neg_lane1", last_v[1], 16'hffe1);
      chk("neg_lane2", last_v[2], 30);
      chk("neg_lane31", last_v[31], 16'hffff);

      // Saturation
      v = '0;
      v[2] = 16'h8000;
      send(v, 2, 2, 8'h33);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_lane1", last_v[1], 16'h7fff);
      t = last_v;
      t[1] = '0;
      chkv("sat_others", t, '0);

      // Illegal select
      chk("pre_illegal_err", err_seg, 0);
      for (int i = 0; i < LANES; i++) v[i] = WIDTH'(i);
      send(v, 1, 1, 8'h44);
      @(negedge clk);
      chk("illegal_err_set", err_seg, 1);
      repeat (3) @(posedge clk);
      #1;
      chkv("illegal_pass", last_v, v);
      chk("illegal_err_held", err_seg, 1);
      send(v, 3, 1, 8'h45);
      send(rand_vec(), 4, 2, 8'h46);
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: tags 1..6, out_ready low for 5 cycles
      fork
         begin
            for (int k = 1; k <= 6; k++)
               send(rand_vec(), $urandom_range(2, 5), $urandom_range(0, 2), 8'(k));
         end
         begin
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      chk("bp_last_tag", last_tag, 6);
      chk("bp_drained", sb.size(), 0);

      // Reset with both stages full
      out_ready = 1'b0;
      send(rand_vec(), 2, 1, 8'h61);
      send(rand_vec(), 3, 2, 8'h62);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      rst = 1'b1;
      pushes -= sb.size();
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_err_seg", err_seg, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      send(rand_vec(), 4, 1, 8'h63);
      @(negedge clk);
      chk("post_rst_cycle1_valid", out_valid, 0);
      @(negedge clk);
      chk("post_rst_cycle2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      chk("post_rst_tag", last_tag, 8'h63);

      // Randomized traffic with random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rand_vec(), $urandom_range(0, 7), $urandom_range(0, 3), 8'($urandom));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("final_drain_empty", sb.size(), 0);
      chk("push_pop_balance", pops, pushes);
      chk("final_err_sticky", err_seg, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
